// File: rtl/pad_ctrl_pkg.sv
// Shared types, reset constants and helpers for the PxBIxx pad bank controller.
package pad_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RELEASE,
    TURN,
    ENABLE
  } dir_state_t;

  localparam logic NEN_RST = 1'b1;
  localparam logic PEN_RST = 1'b1;
  localparam logic PU_RST  = 1'b0;
  localparam logic PD_RST  = 1'b1;

  // Pull-up wins when both pulls are requested on the same pad.
  function automatic logic pd_after_conflict(input logic up, input logic dn);
    return dn & ~up;
  endfunction

endpackage

// File: rtl/pad_in_filter.sv
// Single-pad input path: 2-flop synchroniser, optional debounce, edge detect.
// Debounce is built only when GPIO_DEBOUNCE_EN is defined.
module pad_in_filter #(
  parameter int DB_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_d,
  output logic in_val,
  output logic in_rise,
  output logic in_fall
);
  import pad_ctrl_pkg::*;

  logic sync_p0, sync_p1;
  logic filt, filt_q;

  // Stage p0/p1: metastability synchroniser; filt_q: edge-detect history
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      filt_q  <= 1'b0;
    end else begin
      sync_p0 <= pad_d;
      sync_p1 <= sync_p0;
      filt_q  <= filt;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int DBW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  logic [DBW-1:0] db_cnt;

  // Count only while a pending change persists; any return to the filtered level restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt <= '0;
      filt   <= 1'b0;
    end else if (sync_p1 == filt) begin
      db_cnt <= '0;
    end else if (db_cnt == DBW'(DB_CYC - 1)) begin
      filt   <= sync_p1;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DBW'(1);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) filt <= 1'b0;
    else     filt <= sync_p1;
  end
`endif

  assign in_val  = filt;
  assign in_rise = filt & ~filt_q;
  assign in_fall = ~filt & filt_q;

endmodule

// File: rtl/pad_gpio_ctrl.sv
// Core-side controller for a bank of PxBIxx bidirectional pads with break-before-make turnaround.
// Define GPIO_DEBOUNCE_EN to enable per-pad input debounce (DB_CYC stable cycles).
module pad_gpio_ctrl #(
  parameter int N_PADS   = 8,
  parameter int TURN_CYC = 2,
  parameter int DB_CYC   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dir_valid,
  output logic              dir_ready,
  input  logic [N_PADS-1:0] dir_oe,
  input  logic [N_PADS-1:0] out_val,
  input  logic [N_PADS-1:0] pull_up,
  input  logic [N_PADS-1:0] pull_dn,
  input  logic [1:0]        slew_cfg,
  output logic [N_PADS-1:0] pad_a,
  output logic [N_PADS-1:0] pad_nen,
  output logic [N_PADS-1:0] pad_pen,
  output logic [N_PADS-1:0] pad_pu,
  output logic [N_PADS-1:0] pad_pd,
  output logic [N_PADS-1:0] pad_conof,
  output logic [N_PADS-1:0] pad_sonof,
  input  logic [N_PADS-1:0] pad_d,
  output logic [N_PADS-1:0] in_val,
  output logic [N_PADS-1:0] in_rise,
  output logic [N_PADS-1:0] in_fall,
  output logic              busy
);
  import pad_ctrl_pkg::*;

  localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  dir_state_t        state, state_d;
  logic [N_PADS-1:0] req, req_d;
  logic [N_PADS-1:0] cur_oe, cur_oe_d;
  logic [N_PADS-1:0] nen_d;
  logic [TW-1:0]     cnt, cnt_d;
  logic [N_PADS-1:0] pd_res;

  assign busy      = (state != IDLE);
  assign dir_ready = ~busy;

  // Drivers being dropped are released on the handshake edge; new drivers only turn on in ENABLE.
  always_comb begin
    state_d  = state;
    req_d    = req;
    cur_oe_d = cur_oe;
    cnt_d    = cnt;
    nen_d    = pad_nen;
    case (state)
      IDLE: begin
        if (dir_valid) begin
          req_d   = dir_oe;
          nen_d   = pad_nen | (cur_oe & ~dir_oe);
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        cur_oe_d = cur_oe & req;
        if (~|(~cur_oe & req)) begin
          state_d = IDLE;
        end else if (TURN_CYC == 1) begin
          state_d = ENABLE;
        end else begin
          cnt_d   = TW'(TURN_CYC - 1);
          state_d = TURN;
        end
      end
      TURN: begin
        cnt_d = cnt - TW'(1);
        if (cnt == TW'(1)) state_d = ENABLE;
      end
      ENABLE: begin
        nen_d    = ~req;
        cur_oe_d = req;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      req     <= '0;
      cur_oe  <= '0;
      cnt     <= '0;
      pad_nen <= {N_PADS{NEN_RST}};
    end else begin
      state   <= state_d;
      req     <= req_d;
      cur_oe  <= cur_oe_d;
      cnt     <= cnt_d;
      pad_nen <= nen_d;
    end
  end

  always_comb begin
    pd_res = '0;
    for (int i = 0; i < N_PADS; i++) pd_res[i] = pd_after_conflict(pull_up[i], pull_dn[i]);
  end

  // Stage p0: registered data, pull and slew controls
  always_ff @(posedge clk) begin
    if (rst) begin
      pad_a     <= '0;
      pad_pu    <= {N_PADS{PU_RST}};
      pad_pd    <= {N_PADS{PD_RST}};
      pad_pen   <= {N_PADS{PEN_RST}};
      pad_conof <= '0;
      pad_sonof <= '0;
    end else begin
      pad_a     <= out_val;
      pad_pu    <= pull_up;
      pad_pd    <= pd_res;
      pad_pen   <= pull_up | pull_dn;
      pad_conof <= {N_PADS{slew_cfg[1]}};
      pad_sonof <= {N_PADS{slew_cfg[0]}};
    end
  end

  for (genvar g = 0; g < N_PADS; g++) begin : g_pad
    pad_in_filter #(.DB_CYC(DB_CYC)) u_filt (
      .clk    (clk),
      .rst    (rst),
      .pad_d  (pad_d[g]),
      .in_val (in_val[g]),
      .in_rise(in_rise[g]),
      .in_fall(in_fall[g])
    );
  end

endmodule
